// File: rtl/rf_pkg.sv
// ============================================================================
// rf_pkg
// Shared types and default sizing for the multi-port register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rf_pkg;

  // Clear sequencer state; explicit 1-bit encoding
  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_NREAD  = 2;

endpackage : rf_pkg

`default_nettype wire

// File: rtl/rf_clear_seq.sv
// ============================================================================
// rf_clear_seq
// Walks every entry of the register file writing zero, once after reset and
// again whenever a clear is requested while idle. busy is high while walking.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State register and clear counter; reset restarts the walk from entry 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: one entry per edge while clearing, requests ignored mid-walk
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_IDLE: begin
        if (clear_req) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      RF_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = RF_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: decoded straight from the state register
  always_comb begin
    busy     = (state_q == RF_CLEAR);
    clr_we   = (state_q == RF_CLEAR);
    clr_addr = cnt_q;
  end

endmodule : rf_clear_seq

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp
// Multi-port register file: NREAD asynchronous read ports plus a debug read
// port, two prioritised write ports (port 1 wins), entry 0 reads as zero, and
// a hardware clear sequencer that zeroes the array after reset or on request.
// Optional macro RF_BYPASS_EN: same-cycle write-to-read forwarding.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NREAD  = DEFAULT_NREAD
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clear_req,
  output logic                    busy,
  input  logic                    wen0,
  input  logic [ADDR_W-1:0]       waddr0,
  input  logic [DATA_W-1:0]       wdata0,
  input  logic                    wen1,
  input  logic [ADDR_W-1:0]       waddr1,
  input  logic [DATA_W-1:0]       wdata1,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0]       test_addr,
  output logic [DATA_W-1:0]       test_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Index NREAD is the debug port; it shares the read/bypass rules
  logic [ADDR_W-1:0] rd_addr [NREAD+1];
  logic [DATA_W-1:0] rd_data [NREAD+1];

  rf_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .resetn    (resetn),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // Write mux: clear walk owns the array while busy, otherwise port 1 over port 0
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (clr_we) begin
      mem_d[clr_addr] = '0;
    end else begin
      if (wen0 && (waddr0 != '0)) mem_d[waddr0] = wdata0;
      if (wen1 && (waddr1 != '0)) mem_d[waddr1] = wdata1;
    end
  end

  // Array storage; contents are deliberately not reset, the clear walk zeroes them
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  generate
    for (genvar k = 0; k <= NREAD; k++) begin : g_read
      if (k < NREAD) begin : g_port
        assign rd_addr[k] = raddr[k*ADDR_W +: ADDR_W];
        assign rdata[k*DATA_W +: DATA_W] = rd_data[k];
      end else begin : g_test
        assign rd_addr[k] = test_addr;
        assign test_data  = rd_data[k];
      end

      // Read select: zero while clearing or for entry 0, else stored (or forwarded) data
      always_comb begin
        rd_data[k] = '0;
        if (!busy && (rd_addr[k] != '0)) begin
          rd_data[k] = mem_q[rd_addr[k]];
`ifdef RF_BYPASS_EN
          if (wen1 && (waddr1 == rd_addr[k])) begin
            rd_data[k] = wdata1;
          end else if (wen0 && (waddr0 == rd_addr[k])) begin
            rd_data[k] = wdata0;
          end
`endif
        end
      end
    end
  endgenerate

endmodule : regfile_mp

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// tb_regfile_mp
// Directed self-checking bench for regfile_mp (DATA_W=32, ADDR_W=5, NREAD=2).
// Expectations follow RF_BYPASS_EN when the bench is built with it defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREAD  = 2;
  localparam int DEPTH  = 32;

  logic                    clk;
  logic                    resetn;
  logic                    clear_req;
  logic                    busy;
  logic                    wen0;
  logic [ADDR_W-1:0]       waddr0;
  logic [DATA_W-1:0]       wdata0;
  logic                    wen1;
  logic [ADDR_W-1:0]       waddr1;
  logic [DATA_W-1:0]       wdata1;
  logic [NREAD*ADDR_W-1:0] raddr;
  logic [NREAD*DATA_W-1:0] rdata;
  logic [ADDR_W-1:0]       test_addr;
  logic [DATA_W-1:0]       test_data;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_mp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .clear_req (clear_req),
    .busy      (busy),
    .wen0      (wen0),
    .waddr0    (waddr0),
    .wdata0    (wdata0),
    .wen1      (wen1),
    .waddr1    (waddr1),
    .wdata1    (wdata1),
    .raddr     (raddr),
    .rdata     (rdata),
    .test_addr (test_addr),
    .test_data (test_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs settle 1 unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rd(input int k);
    return rdata[k*DATA_W +: DATA_W];
  endfunction

  task automatic set_raddr(input int k, input logic [ADDR_W-1:0] a);
    raddr[k*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic idle_inputs();
    wen0 = 1'b0; waddr0 = '0; wdata0 = '0;
    wen1 = 1'b0; waddr1 = '0; wdata1 = '0;
    clear_req = 1'b0;
  endtask

  task automatic write1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wen1 = 1'b1; waddr1 = a; wdata1 = d;
    tick();
    wen1 = 1'b0;
  endtask

  // Count edges until busy falls, bounded so a stuck sequencer cannot hang
  task automatic count_busy(output int edges);
    edges = 0;
    while (busy === 1'b1 && edges < 3 * DEPTH) begin
      tick();
      edges++;
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      test_addr = a[ADDR_W-1:0];
      #1;
      n_cmp++;
      if (test_data !== '0) begin
        n_bad++;
        $display("FAIL %s addr=%0d got=%h exp=0", name, a, test_data);
      end
    end
  endtask

  task automatic test_reset();
    int edges;
    idle_inputs();
    resetn = 1'b0;
    raddr = '0;
    test_addr = 5'd3;
    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h0000_DEAD;
    set_raddr(0, 5'd3);
    set_raddr(1, 5'd3);
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
    n_cmp++;
    if (rdata !== '0 || test_data !== '0) begin
      n_bad++; $display("FAIL reset_rdata got=%h/%h exp=0", rdata, test_data);
    end
    resetn = 1'b1;
    count_busy(edges);
    n_cmp++;
    if (edges !== DEPTH) begin n_bad++; $display("FAIL reset_busy_len got=%0d exp=%0d", edges, DEPTH); end
    n_cmp++;
    if (rd(0) !== '0) begin n_bad++; $display("FAIL reset_addr3 got=%h exp=0", rd(0)); end
    wen0 = 1'b0;
    check_all_zero("reset_clear");
  endtask

  task automatic test_write_priority();
    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h0000_1111;
    wen1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h0000_2222;
    tick();
    idle_inputs();
    set_raddr(0, 5'd5);
    #1;
    n_cmp++;
    if (rd(0) !== 32'h0000_2222) begin n_bad++; $display("FAIL prio_addr5 got=%h exp=00002222", rd(0)); end
    wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h0000_9999;
    wen1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'hA0A0_A0A0;
    tick();
    idle_inputs();
    set_raddr(0, 5'd9);
    set_raddr(1, 5'd10);
    #1;
    n_cmp++;
    if (rd(0) !== 32'h0000_9999) begin n_bad++; $display("FAIL wr0_addr9 got=%h exp=00009999", rd(0)); end
    n_cmp++;
    if (rd(1) !== 32'hA0A0_A0A0) begin n_bad++; $display("FAIL wr1_addr10 got=%h exp=a0a0a0a0", rd(1)); end
  endtask

  task automatic test_addr0();
    wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
    wen1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
    set_raddr(0, 5'd0);
    set_raddr(1, 5'd0);
    test_addr = 5'd0;
    #1;
    n_cmp++;
    if (rdata !== '0 || test_data !== '0) begin
      n_bad++; $display("FAIL addr0_same got=%h/%h exp=0", rdata, test_data);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rdata !== '0 || test_data !== '0) begin
      n_bad++; $display("FAIL addr0_after got=%h/%h exp=0", rdata, test_data);
    end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] exp_now;
    write1(5'd7, 32'h0000_7777);
    wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h0000_ABCD;
    set_raddr(0, 5'd7);
    test_addr = 5'd7;
    #1;
`ifdef RF_BYPASS_EN
    exp_now = 32'h0000_ABCD;
`else
    exp_now = 32'h0000_7777;
`endif
    n_cmp++;
    if (rd(0) !== exp_now) begin n_bad++; $display("FAIL bypass_port0 got=%h exp=%h", rd(0), exp_now); end
    n_cmp++;
    if (test_data !== exp_now) begin n_bad++; $display("FAIL bypass_test got=%h exp=%h", test_data, exp_now); end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rd(0) !== 32'h0000_ABCD) begin n_bad++; $display("FAIL bypass_next got=%h exp=0000abcd", rd(0)); end
    // Double match: port 1 must win both the forward and the store
    wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h0000_0000_5555;
    wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h0000_6666;
    #1;
`ifdef RF_BYPASS_EN
    exp_now = 32'h0000_6666;
`else
    exp_now = 32'h0000_ABCD;
`endif
    n_cmp++;
    if (rd(0) !== exp_now) begin n_bad++; $display("FAIL bypass_double got=%h exp=%h", rd(0), exp_now); end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rd(0) !== 32'h0000_6666) begin n_bad++; $display("FAIL double_store got=%h exp=00006666", rd(0)); end
  endtask

  task automatic test_clear();
    int edges;
    int bad_reads;
    for (int a = 1; a < DEPTH; a++) begin
      write1(a[ADDR_W-1:0], 32'h1000_0000 + a);
    end
    test_addr = 5'd17;
    #1;
    n_cmp++;
    if (test_data !== 32'h1000_0011) begin n_bad++; $display("FAIL fill_addr17 got=%h exp=10000011", test_data); end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    // Writes, a second request and reads during the walk
    edges = 0;
    bad_reads = 0;
    set_raddr(0, 5'd4);
    set_raddr(1, 5'd20);
    while (busy === 1'b1 && edges < 3 * DEPTH) begin
      clear_req = (edges == 10);
      wen1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h0BAD_0BAD;
      #1;
      if (rdata !== '0 || test_data !== '0) bad_reads++;
      tick();
      edges++;
    end
    idle_inputs();
    n_cmp++;
    if (edges !== DEPTH) begin n_bad++; $display("FAIL clear_len got=%0d exp=%0d", edges, DEPTH); end
    n_cmp++;
    if (bad_reads !== 0) begin n_bad++; $display("FAIL clear_reads nonzero_cycles=%0d exp=0", bad_reads); end
    check_all_zero("clear_after");
  endtask

  task automatic test_reset_midclear();
    int edges;
    write1(5'd12, 32'h1234_5678);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL midreset_busy got=%b exp=1", busy); end
    repeat (2) tick();
    resetn = 1'b1;
    count_busy(edges);
    n_cmp++;
    if (edges !== DEPTH) begin n_bad++; $display("FAIL midreset_len got=%0d exp=%0d", edges, DEPTH); end
    check_all_zero("midreset_after");
  endtask

  initial begin
    test_reset();
    test_write_priority();
    test_addr0();
    test_bypass();
    test_clear();
    test_reset_midclear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_regfile_mp

`default_nettype wire
